display_sr_receiver: RTL

Receiving end of the display shift-register link: emulates the 74HC595 chain that the output driver feeds through its serial data, shift-clock and latch pins. Every serial frame is reassembled into per-digit segment bytes and decoded back to hex values with blank and minus flags. Used for on-chip loopback self-test and as the bench scoreboard front end. Only pin-level behaviour is checked, so it has no dependence on the driver's internals.

---
 rtl/display_pkg.sv | 79 +++++++
 rtl/seg7_decoder.sv | 43 ++++
 rtl/display_sr_receiver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// ============================================================================
// Module  : display_pkg
// Brief   : Shared 7-segment encoding for the display driver and receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

  localparam int SEG_A_BIT  = 0;
  localparam int SEG_B_BIT  = 1;
  localparam int SEG_C_BIT  = 2;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 4;
  localparam int SEG_F_BIT  = 5;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  localparam logic [7:0] SEG_A = 8'(1 << SEG_A_BIT);
  localparam logic [7:0] SEG_B = 8'(1 << SEG_B_BIT);
  localparam logic [7:0] SEG_C = 8'(1 << SEG_C_BIT);
  localparam logic [7:0] SEG_D = 8'(1 << SEG_D_BIT);
  localparam logic [7:0] SEG_E = 8'(1 << SEG_E_BIT);
  localparam logic [7:0] SEG_F = 8'(1 << SEG_F_BIT);
  localparam logic [7:0] SEG_G = 8'(1 << SEG_G_BIT);

  localparam logic [7:0] SEG_HEX_0 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
  localparam logic [7:0] SEG_HEX_1 = SEG_B | SEG_C;
  localparam logic [7:0] SEG_HEX_2 = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
  localparam logic [7:0] SEG_HEX_3 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
  localparam logic [7:0] SEG_HEX_4 = SEG_B | SEG_C | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_5 = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_6 = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_7 = SEG_A | SEG_B | SEG_C;
  localparam logic [7:0] SEG_HEX_8 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_9 = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_A = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_B = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_C = SEG_A | SEG_D | SEG_E | SEG_F;
  localparam logic [7:0] SEG_HEX_D = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
  localparam logic [7:0] SEG_HEX_E = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
  localparam logic [7:0] SEG_HEX_F = SEG_A | SEG_E | SEG_F | SEG_G;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_MINUS = SEG_G;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       minus;
    logic       err;
  } seg_decode_t;

  function automatic logic [7:0] seg_encode(input logic [3:0] value);
    logic [7:0] seg;
    case (value)
      4'h0:    seg = SEG_HEX_0;
      4'h1:    seg = SEG_HEX_1;
      4'h2:    seg = SEG_HEX_2;
      4'h3:    seg = SEG_HEX_3;
      4'h4:    seg = SEG_HEX_4;
      4'h5:    seg = SEG_HEX_5;
      4'h6:    seg = SEG_HEX_6;
      4'h7:    seg = SEG_HEX_7;
      4'h8:    seg = SEG_HEX_8;
      4'h9:    seg = SEG_HEX_9;
      4'hA:    seg = SEG_HEX_A;
      4'hB:    seg = SEG_HEX_B;
      4'hC:    seg = SEG_HEX_C;
      4'hD:    seg = SEG_HEX_D;
      4'hE:    seg = SEG_HEX_E;
      default: seg = SEG_HEX_F;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module  : seg7_decoder
// Brief   : Combinational segment byte to hex digit / blank / minus / error.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder
  import display_pkg::*;
(
  input  logic [7:0]  i_byte,
  output seg_decode_t o_dec
);

  logic [6:0] w_segs;
  logic       w_dp;

  assign w_segs = i_byte[SEG_G_BIT:SEG_A_BIT];
  assign w_dp   = i_byte[SEG_DP_BIT];

  // A lit dp never forms a known glyph, so it always falls through to err.
  always_comb begin
    o_dec = '0;
    if (i_byte == SEG_BLANK) begin
      o_dec.blank = 1'b1;
    end else if (i_byte == SEG_MINUS) begin
      o_dec.minus = 1'b1;
    end else begin
      o_dec.err = 1'b1;
      if (!w_dp) begin
        for (int v = 0; v < 16; v++) begin
          if ({1'b0, w_segs} == seg_encode(4'(v))) begin
            o_dec.digit = 4'(v);
            o_dec.err   = 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_sr_receiver.sv
// ============================================================================
// Module  : display_sr_receiver
// Brief   : 74HC595-chain emulator: reassembles serial frames and decodes digits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module display_sr_receiver
  import display_pkg::*;
#(
  parameter int NUM_7_SEG_DISPLAYS = 5,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_sr_data,
  input  logic                            i_sr_clk,
  input  logic                            i_sr_latch,
  output logic [8*NUM_7_SEG_DISPLAYS-1:0] o_frame,
  output logic [4*NUM_7_SEG_DISPLAYS-1:0] o_digits,
  output logic [NUM_7_SEG_DISPLAYS-1:0]   o_blank,
  output logic [NUM_7_SEG_DISPLAYS-1:0]   o_minus,
  output logic [NUM_7_SEG_DISPLAYS-1:0]   o_decode_err,
  output logic                            o_frame_valid,
  input  logic                            i_frame_ready,
  output logic                            o_short_frame,
  output logic                            o_long_frame,
  output logic                            o_overrun
);

  localparam int N  = NUM_7_SEG_DISPLAYS;
  localparam int FW = 8 * N;
  localparam int CW = $clog2(FW + 2);

  localparam logic [CW-1:0] c_FW  = CW'(FW);
  localparam logic [CW-1:0] c_SAT = CW'(FW + 1);

  logic [SYNC_STAGES-1:0] r_sync_data;
  logic [SYNC_STAGES-1:0] r_sync_clk;
  logic [SYNC_STAGES-1:0] r_sync_latch;
  logic                   r_clk_d;
  logic                   r_latch_d;

  logic                   w_data;
  logic                   w_clk_rise;
  logic                   w_latch_rise;

  logic [FW-1:0]          r_shift;
  logic [CW-1:0]          r_count;

  seg_decode_t            w_dec [N];
  logic [4*N-1:0]         w_digits;
  logic [N-1:0]           w_blank;
  logic [N-1:0]           w_minus;
  logic [N-1:0]           w_err;

  logic [FW-1:0]          r_frame;
  logic [4*N-1:0]         r_digits;
  logic [N-1:0]           r_blank;
  logic [N-1:0]           r_minus;
  logic [N-1:0]           r_err;
  logic                   r_valid;
  logic                   r_short;
  logic                   r_long;
  logic                   r_overrun;
  logic                   w_accept;

  // Edge detection compares the last sync stage against one more registered copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_data  <= '0;
      r_sync_clk   <= '0;
      r_sync_latch <= '0;
      r_clk_d      <= 1'b0;
      r_latch_d    <= 1'b0;
    end else begin
      r_sync_data  <= {r_sync_data[SYNC_STAGES-2:0], i_sr_data};
      r_sync_clk   <= {r_sync_clk[SYNC_STAGES-2:0], i_sr_clk};
      r_sync_latch <= {r_sync_latch[SYNC_STAGES-2:0], i_sr_latch};
      r_clk_d      <= r_sync_clk[SYNC_STAGES-1];
      r_latch_d    <= r_sync_latch[SYNC_STAGES-1];
    end
  end

  assign w_data       = r_sync_data[SYNC_STAGES-1];
  assign w_clk_rise   = r_sync_clk[SYNC_STAGES-1] & ~r_clk_d;
  assign w_latch_rise = r_sync_latch[SYNC_STAGES-1] & ~r_latch_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (w_clk_rise) begin
      r_shift <= {r_shift[FW-2:0], w_data};
    end
  end

  // A shift coinciding with the latch belongs to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_latch_rise) begin
      r_count <= w_clk_rise ? CW'(1) : '0;
    end else if (w_clk_rise && (r_count != c_SAT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dec
      seg7_decoder u_dec (
        .i_byte (r_shift[8*gi +: 8]),
        .o_dec  (w_dec[gi])
      );
      assign w_digits[4*gi +: 4] = w_dec[gi].digit;
      assign w_blank[gi]         = w_dec[gi].blank;
      assign w_minus[gi]         = w_dec[gi].minus;
      assign w_err[gi]           = w_dec[gi].err;
    end
  endgenerate

  assign w_accept = r_valid & i_frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame  <= '0;
      r_digits <= '0;
      r_blank  <= '0;
      r_minus  <= '0;
      r_err    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
    end else if (w_latch_rise) begin
      r_frame  <= r_shift;
      r_digits <= w_digits;
      r_blank  <= w_blank;
      r_minus  <= w_minus;
      r_err    <= w_err;
      r_short  <= (r_count < c_FW);
      r_long   <= (r_count > c_FW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= w_latch_rise | (r_valid & ~w_accept);
      r_overrun <= w_latch_rise & r_valid & ~w_accept;
    end
  end

  assign o_frame       = r_frame;
  assign o_digits      = r_digits;
  assign o_blank       = r_blank;
  assign o_minus       = r_minus;
  assign o_decode_err  = r_err;
  assign o_frame_valid = r_valid;
  assign o_short_frame = r_short;
  assign o_long_frame  = r_long;
  assign o_overrun     = r_overrun;

endmodule

`default_nettype wire
